// File: rtl/alu_acc_seq_if.sv
// Operand/opcode issue channel between the control unit and the accumulator ALU.
// An op transfers on a rising clk edge where op_valid && op_ready; the source holds op_code/operand until then.
interface alu_acc_seq_if #(
  parameter int W = 16
);
  logic         op_valid;
  logic         op_ready;
  logic [3:0]   op_code;
  logic [W-1:0] operand;
  logic [W-1:0] acc_out;
  logic [W-1:0] mq_out;
  logic [3:0]   flags;
  logic         done;

  modport master (
    output op_valid, op_code, operand,
    input  op_ready, acc_out, mq_out, flags, done
  );

  modport slave (
    input  op_valid, op_code, operand,
    output op_ready, acc_out, mq_out, flags, done
  );
endinterface

// File: rtl/alu_acc_seq.sv
// Accumulator ALU: single-cycle ADD/SUB/logic/shift/LOAD/CLR plus sequential
// shift-add MUL and restoring DIV producing {MQ,ACC}; flags are {Z,N,C,V}.
module alu_acc_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_acc_seq_if.slave io,
  output logic [1:0]   state_o
);
  localparam int CW = $clog2(W);

  localparam logic [3:0] OP_CLR  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_NOT  = 4'd10;
  localparam logic [3:0] OP_LOAD = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  acc_q, mq_q, opnd_q, hi_q, lo_q;
  logic [3:0]    flags_q;
  logic          done_q;

  // Working pair hi_q:lo_q keeps ACC/MQ stable until a multi-cycle op finishes.
  logic          accept;
  logic [W:0]    add_x;
  logic [W-1:0]  sub_x;
  logic [W-1:0]  sc_res, sc_mq;
  logic          sc_c, sc_v, sc_wr;
  logic [W:0]    mul_sum;
  logic [W-1:0]  mul_hi_d, mul_lo_d;
  logic [W:0]    div_sh;
  logic          div_ge;
  logic [W-1:0]  div_diff, div_hi_d, div_lo_d;
  logic          last_iter;

  assign accept    = io.op_valid && (state_q == ST_IDLE);
  assign last_iter = (cnt_q == CW'(W - 1));
  assign add_x     = {1'b0, acc_q} + {1'b0, io.operand};
  assign sub_x     = acc_q - io.operand;

  always_comb begin
    sc_res = acc_q;
    sc_mq  = mq_q;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_wr  = 1'b1;
    case (io.op_code)
      OP_CLR:  begin sc_res = '0; sc_mq = '0; end
      OP_ADD:  begin
        sc_res = add_x[W-1:0];
        sc_c   = add_x[W];
        sc_v   = (acc_q[W-1] == io.operand[W-1]) && (add_x[W-1] != acc_q[W-1]);
      end
      OP_SUB:  begin
        sc_res = sub_x;
        sc_c   = acc_q < io.operand;
        sc_v   = (acc_q[W-1] != io.operand[W-1]) && (sub_x[W-1] != acc_q[W-1]);
      end
      // Only reached with a zero divisor; non-zero divides go through the FSM.
      OP_DIV:  begin sc_res = '1; sc_mq = acc_q; sc_v = 1'b1; end
      OP_SHR:  begin sc_res = acc_q >> 1; sc_c = acc_q[0]; end
      OP_SHL:  begin sc_res = acc_q << 1; sc_c = acc_q[W-1]; end
      OP_AND:  sc_res = acc_q & io.operand;
      OP_OR:   sc_res = acc_q | io.operand;
      OP_NOT:  sc_res = ~acc_q;
      OP_LOAD: sc_res = io.operand;
      default: sc_wr  = 1'b0;
    endcase
  end

  // One shift-add step: multiplier bits leave lo_q from the bottom, product bits enter from the top.
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_hi_d = mul_sum[W:1];
  assign mul_lo_d = {mul_sum[0], lo_q[W-1:1]};

  // One restoring step: partial remainder fits in W bits once the trial subtract succeeds.
  assign div_sh   = {hi_q, lo_q[W-1]};
  assign div_ge   = div_sh >= {1'b0, opnd_q};
  assign div_diff = div_sh[W-1:0] - opnd_q;
  assign div_hi_d = div_ge ? div_diff : div_sh[W-1:0];
  assign div_lo_d = {lo_q[W-2:0], div_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (io.op_code == OP_MUL) begin
              state_q <= ST_MUL;
              cnt_q   <= '0;
              hi_q    <= '0;
              lo_q    <= io.operand;
              opnd_q  <= acc_q;
            end else if ((io.op_code == OP_DIV) && (io.operand != '0)) begin
              state_q <= ST_DIV;
              cnt_q   <= '0;
              hi_q    <= '0;
              lo_q    <= acc_q;
              opnd_q  <= io.operand;
            end else if (sc_wr) begin
              acc_q   <= sc_res;
              mq_q    <= sc_mq;
              flags_q <= {sc_res == '0, sc_res[W-1], sc_c, sc_v};
              done_q  <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          hi_q  <= mul_hi_d;
          lo_q  <= mul_lo_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= mul_lo_d;
            mq_q    <= mul_hi_d;
            flags_q <= {mul_lo_d == '0, mul_lo_d[W-1], mul_hi_d != '0, 1'b0};
            done_q  <= 1'b1;
          end
        end
        ST_DIV: begin
          hi_q  <= div_hi_d;
          lo_q  <= div_lo_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= div_lo_d;
            mq_q    <= div_hi_d;
            flags_q <= {div_lo_d == '0, div_lo_d[W-1], 2'b00};
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign io.op_ready = (state_q == ST_IDLE);
  assign io.acc_out  = acc_q;
  assign io.mq_out   = mq_q;
  assign io.flags    = flags_q;
  assign io.done     = done_q;
  assign state_o     = state_q;
endmodule

// File: tb/tb_alu_acc_seq.sv
// Scoreboarded bench for alu_acc_seq: a reference model pushes {acc,mq,flags} per op,
// popped and compared when done pulses.
module tb_alu_acc_seq;
  localparam int W = 16;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_CLR  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_NOT  = 4'd10;
  localparam logic [3:0] OP_LOAD = 4'd11;

  // Clock / reset
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  alu_acc_seq_if #(.W(W)) bus ();

  alu_acc_seq #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .io      (bus),
    .state_o (state_dbg)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Scoreboard and reference model
  logic [2*W+3:0] exp_q[$];
  logic [W-1:0]   m_acc = '0;
  logic [W-1:0]   m_mq = '0;
  logic [3:0]     m_flags = '0;

  function automatic logic [W-1:0] rnd();
    return W'($urandom());
  endfunction

  function automatic longint sval(input logic [W-1:0] x);
    return x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
  endfunction

  task automatic model_op(input logic [3:0] op, input logic [W-1:0] b);
    logic [W-1:0]   a, r, q;
    logic           c, v;
    logic [2*W-1:0] a2, b2, p;
    longint         s, smax, smin;
    a = m_acc; r = m_acc; q = m_mq; c = 1'b0; v = 1'b0;
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    case (op)
      OP_CLR:  begin r = '0; q = '0; end
      OP_ADD:  begin
        r = a + b;
        c = (longint'(a) + longint'(b)) >= (longint'(1) << W);
        s = sval(a) + sval(b);
        v = (s > smax) || (s < smin);
      end
      OP_SUB:  begin
        r = a - b;
        c = a < b;
        s = sval(a) - sval(b);
        v = (s > smax) || (s < smin);
      end
      OP_MUL:  begin
        a2 = {{W{1'b0}}, a}; b2 = {{W{1'b0}}, b};
        p = a2 * b2;
        r = p[W-1:0]; q = p[2*W-1:W];
        c = (q != '0);
      end
      OP_DIV:  begin
        if (b == '0) begin r = '1; q = a; v = 1'b1; end
        else begin r = a / b; q = a % b; end
      end
      OP_SHR:  begin r = a >> 1; c = a[0]; end
      OP_SHL:  begin r = a << 1; c = a[W-1]; end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOT:  r = ~a;
      OP_LOAD: r = b;
      default: r = a;
    endcase
    m_acc = r; m_mq = q; m_flags = {r == '0, r[W-1], c, v};
    exp_q.push_back({r, q, m_flags});
  endtask

  // Waits (bounded) for done, counting busy samples; optionally pokes op_valid while busy.
  task automatic check_result(input string name, input int lat, input bit poke);
    int n, busy;
    logic [2*W+3:0] e;
    n = 0; busy = 0;
    while (n < lat + 4) begin
      if (bus.done === 1'b1) break;
      if (bus.op_ready === 1'b0) busy++;
      if (poke) begin
        bus.op_valid = 1'b1; bus.op_code = OP_ADD; bus.operand = rnd();
      end
      @(posedge clk); #1;
      n++;
    end
    if (poke) bus.op_valid = 1'b0;
    tests_run++;
    if (bus.done !== 1'b1) begin
      $display("FAIL %s done: not seen within %0d cycles", name, lat + 4);
      tests_failed++;
    end else if (n != lat) begin
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, lat);
      tests_failed++;
    end
    tests_run++;
    if (busy != lat) begin
      $display("FAIL %s ready_low: got %0d cycles, expected %0d", name, busy, lat);
      tests_failed++;
    end
    tests_run++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s scoreboard: result with empty expected queue", name);
      tests_failed++;
    end else begin
      e = exp_q.pop_front();
      if ({bus.acc_out, bus.mq_out, bus.flags} !== e) begin
        $display("FAIL %s result: acc=%h mq=%h flags=%b, expected acc=%h mq=%h flags=%b",
                 name, bus.acc_out, bus.mq_out, bus.flags,
                 e[2*W+3:W+4], e[W+3:4], e[3:0]);
        tests_failed++;
      end
    end
  endtask

  // Driver: assumes op_ready=1 and is called #1 after a rising edge.
  task automatic do_op(input string name, input logic [3:0] op, input logic [W-1:0] b,
                       input bit poke);
    bus.op_valid = 1'b1; bus.op_code = op; bus.operand = b;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    if (op == OP_NOP || op >= 4'd12) begin
      tests_run++;
      if (bus.done !== 1'b0 || {bus.acc_out, bus.mq_out, bus.flags} !== {m_acc, m_mq, m_flags}) begin
        $display("FAIL %s nop: done=%b acc=%h mq=%h flags=%b, expected done=0 acc=%h mq=%h flags=%b",
                 name, bus.done, bus.acc_out, bus.mq_out, bus.flags, m_acc, m_mq, m_flags);
        tests_failed++;
      end
      return;
    end
    model_op(op, b);
    check_result(name, (op == OP_MUL || (op == OP_DIV && b != '0)) ? W : 0, poke);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.op_valid = 1'b0; bus.op_code = OP_NOP; bus.operand = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (bus.acc_out !== '0 || bus.mq_out !== '0 || bus.flags !== 4'b0000) begin
      $display("FAIL reset regs: acc=%h mq=%h flags=%b, expected all zero",
               bus.acc_out, bus.mq_out, bus.flags);
      tests_failed++;
    end
    tests_run++;
    if (bus.op_ready !== 1'b1 || bus.done !== 1'b0) begin
      $display("FAIL reset hs: op_ready=%b done=%b, expected 1 0", bus.op_ready, bus.done);
      tests_failed++;
    end
    tests_run++;
    if (state_dbg !== 2'd0) begin
      $display("FAIL reset state: got %0d, expected 0 (IDLE)", state_dbg);
      tests_failed++;
    end
    rst_n = 1'b1;
    m_acc = '0; m_mq = '0; m_flags = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_nop();
    do_op("nop_at_reset", OP_NOP, 16'h1234, 0);
    do_op("load_a5", OP_LOAD, 16'hA5A5, 0);
    do_op("nop0", OP_NOP, 16'hFFFF, 0);
    do_op("nop13", 4'd13, 16'h0001, 0);
    do_op("nop15", 4'd15, 16'h8000, 0);
  endtask

  task automatic test_add_sub();
    do_op("add_load", OP_LOAD, 16'hFFFF, 0);
    do_op("add_wrap", OP_ADD, 16'h0001, 0);
    tests_run++;
    if (bus.acc_out !== 16'h0000 || bus.flags !== 4'b1010) begin
      $display("FAIL add_wrap_const: acc=%h flags=%b, expected 0000 1010", bus.acc_out, bus.flags);
      tests_failed++;
    end
    do_op("sub_borrow", OP_SUB, 16'h0001, 0);
    for (int i = 0; i < 6; i++) begin
      do_op("add_rnd", OP_ADD, rnd(), 0);
      do_op("sub_rnd", OP_SUB, rnd(), 0);
    end
  endtask

  task automatic test_overflow();
    do_op("ovf_load", OP_LOAD, 16'h7FFF, 0);
    do_op("ovf_add", OP_ADD, 16'h0001, 0);
    tests_run++;
    if (bus.acc_out !== 16'h8000 || bus.flags !== 4'b0101) begin
      $display("FAIL ovf_add_const: acc=%h flags=%b, expected 8000 0101", bus.acc_out, bus.flags);
      tests_failed++;
    end
    do_op("ovf_load2", OP_LOAD, 16'h8000, 0);
    do_op("ovf_sub", OP_SUB, 16'h0001, 0);
  endtask

  task automatic test_logic();
    logic [3:0] ops [8];
    ops = '{OP_AND, OP_OR, OP_NOT, OP_SHR, OP_SHL, OP_LOAD, OP_CLR, OP_ADD};
    do_op("logic_load", OP_LOAD, rnd(), 0);
    do_op("mq_set", OP_DIV, 16'h0000, 0);
    for (int i = 0; i < 24; i++) begin
      do_op("logic_rnd", ops[$urandom_range(0, 7)], rnd(), 0);
    end
    do_op("shl_msb", OP_LOAD, 16'h8001, 0);
    do_op("shl_c", OP_SHL, 16'h0000, 0);
    do_op("shr_c", OP_LOAD, 16'h0003, 0);
    do_op("shr_c", OP_SHR, 16'h0000, 0);
  endtask

  task automatic test_mul();
    do_op("mul_load", OP_LOAD, 16'h1234, 0);
    do_op("mul_spec", OP_MUL, 16'h0100, 1);
    tests_run++;
    if (bus.acc_out !== 16'h3400 || bus.mq_out !== 16'h0012 || bus.flags[1] !== 1'b1) begin
      $display("FAIL mul_spec_const: acc=%h mq=%h C=%b, expected 3400 0012 1",
               bus.acc_out, bus.mq_out, bus.flags[1]);
      tests_failed++;
    end
    for (int i = 0; i < 4; i++) begin
      do_op("mul_load_rnd", OP_LOAD, rnd(), 0);
      do_op("mul_rnd", OP_MUL, rnd(), (i % 2) == 1);
    end
    do_op("mul_zero", OP_MUL, 16'h0000, 0);
    do_op("mul_max_ld", OP_LOAD, 16'hFFFF, 0);
    do_op("mul_max", OP_MUL, 16'hFFFF, 0);
  endtask

  task automatic test_div();
    do_op("div_load", OP_LOAD, 16'd1000, 0);
    do_op("div_spec", OP_DIV, 16'd7, 1);
    tests_run++;
    if (bus.acc_out !== 16'd142 || bus.mq_out !== 16'd6) begin
      $display("FAIL div_spec_const: acc=%0d mq=%0d, expected 142 6", bus.acc_out, bus.mq_out);
      tests_failed++;
    end
    for (int i = 0; i < 4; i++) begin
      do_op("div_load_rnd", OP_LOAD, rnd(), 0);
      do_op("div_rnd", OP_DIV, W'($urandom_range(1, (i < 2) ? 255 : 65535)), 0);
    end
    do_op("div_big_ld", OP_LOAD, 16'h0005, 0);
    do_op("div_big", OP_DIV, 16'hFFFF, 0);
    do_op("div0_load", OP_LOAD, 16'd5, 0);
    do_op("div0", OP_DIV, 16'h0000, 0);
    tests_run++;
    if (bus.acc_out !== 16'hFFFF || bus.mq_out !== 16'd5 || bus.flags[0] !== 1'b1) begin
      $display("FAIL div0_const: acc=%h mq=%h V=%b, expected FFFF 0005 1",
               bus.acc_out, bus.mq_out, bus.flags[0]);
      tests_failed++;
    end
  endtask

  task automatic test_back_to_back();
    do_op("b2b_load", OP_LOAD, 16'h0003, 0);
    // MUL followed by an ADD held on the bus for the whole busy period.
    bus.op_valid = 1'b1; bus.op_code = OP_MUL; bus.operand = 16'h0005;
    @(posedge clk); #1;
    model_op(OP_MUL, 16'h0005);
    bus.op_code = OP_ADD; bus.operand = 16'h0010;
    model_op(OP_ADD, 16'h0010);
    check_result("b2b_mul", W, 0);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    check_result("b2b_add", 0, 0);
    @(posedge clk); #1;
    tests_run++;
    if (bus.done !== 1'b0) begin
      $display("FAIL done_pulse: done=%b one cycle after completion, expected 0", bus.done);
      tests_failed++;
    end
  endtask

  task automatic test_abort();
    do_op("abort_load", OP_LOAD, 16'h1234, 0);
    bus.op_valid = 1'b1; bus.op_code = OP_MUL; bus.operand = 16'h0100;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.acc_out !== '0 || bus.mq_out !== '0 || bus.flags !== 4'b0000) begin
      $display("FAIL abort regs: acc=%h mq=%h flags=%b, expected all zero",
               bus.acc_out, bus.mq_out, bus.flags);
      tests_failed++;
    end
    tests_run++;
    if (bus.op_ready !== 1'b1 || bus.done !== 1'b0) begin
      $display("FAIL abort hs: op_ready=%b done=%b, expected 1 0", bus.op_ready, bus.done);
      tests_failed++;
    end
    #2;
    rst_n = 1'b1;
    m_acc = '0; m_mq = '0; m_flags = '0;
    exp_q.delete();
    @(posedge clk); #1;
    do_op("abort_add", OP_ADD, 16'h0003, 0);
    tests_run++;
    if (bus.acc_out !== 16'h0003) begin
      $display("FAIL abort_add_const: acc=%h, expected 0003", bus.acc_out);
      tests_failed++;
    end
  endtask

  initial begin
    bus.op_valid = 1'b0; bus.op_code = OP_NOP; bus.operand = '0;
    test_reset();
    test_nop();
    test_add_sub();
    test_overflow();
    test_logic();
    test_mul();
    test_div();
    test_back_to_back();
    test_abort();
    tests_run++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d results never produced, expected 0", exp_q.size());
      tests_failed++;
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
